dct_mac_array: RTL and testbench

//  Parametrised multi-channel multiply-accumulate engine for the fdct_zigzag DCT path. It generalises the single-channel macu.
//  One signed sample stream is broadcast to NCH channels, each with its own coefficient per tap. After NTAP accepted samples,

---
 rtl/dct_mac_array.sv | 113 +++++++++++
 tb/tb_dct_mac_array.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_mac_array.sv
// Multi-channel multiply-accumulate engine: one signed sample stream feeds NCH channels,
// each frame of NTAP samples yields a rounded, saturated result vector behind a valid/ready port.
module dct_mac_array #(
    parameter int DW    = 8,
    parameter int CW    = 12,
    parameter int NCH   = 8,
    parameter int NTAP  = 8,
    parameter int SHIFT = 4,
    parameter int RW    = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic signed [DW-1:0]  s_data,
    input  logic                  s_first,
    input  logic [NCH*CW-1:0]     s_coef,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [NCH*RW-1:0]     m_data,
    output logic [NCH-1:0]        m_ovf,
    output logic                  err_sync
);

    localparam int AW = DW + CW + $clog2(NTAP);
    localparam int PW = DW + CW;
    localparam int TW = $clog2(NTAP);
    localparam int EW = (RW > AW + 1) ? RW : AW + 1;

    localparam logic [TW-1:0]        TAP_LAST = TW'(NTAP - 1);
    localparam logic signed [EW-1:0] RND_BIAS =
        (SHIFT > 0) ? (EW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [EW-1:0] SAT_MAX  = {{(EW-RW+1){1'b0}}, {(RW-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN  = {{(EW-RW+1){1'b1}}, {(RW-1){1'b0}}};
    localparam logic [RW-1:0]        OUT_MAX  = {1'b0, {(RW-1){1'b1}}};
    localparam logic [RW-1:0]        OUT_MIN  = {1'b1, {(RW-1){1'b0}}};

    logic [TW-1:0]        r_tap;
    logic signed [AW-1:0] r_acc [NCH];
    logic                 r_m_valid;
    logic [NCH*RW-1:0]    r_m_data;
    logic [NCH-1:0]       r_m_ovf;
    logic                 r_err_sync;

    logic                 w_last;
    logic                 w_accept;
    logic                 w_resync;
    logic                 w_clear;
    logic                 w_load;
    logic signed [AW-1:0] w_acc_next [NCH];
    logic [NCH*RW-1:0]    w_m_data_next;
    logic [NCH-1:0]       w_ovf_next;

    // Only the last tap must wait for the output register; earlier taps overlap a pending result.
    assign w_last   = (r_tap == TAP_LAST);
    assign s_ready  = ena & ~(w_last & r_m_valid & ~m_ready);
    assign w_accept = ena & s_valid & s_ready;
    assign w_resync = w_accept & s_first & (r_tap != '0);
    assign w_clear  = (r_tap == '0) | w_resync;
    assign w_load   = w_accept & w_last & ~w_resync;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic signed [CW-1:0] w_coef;
        logic signed [PW-1:0] w_prod;
        logic signed [EW-1:0] w_rnd;
        logic                 w_hi;
        logic                 w_lo;

        assign w_coef        = s_coef[i*CW +: CW];
        assign w_prod        = s_data * w_coef;
        assign w_acc_next[i] = (w_clear ? '0 : r_acc[i]) + {{(AW-PW){w_prod[PW-1]}}, w_prod};
        // Widened by one bit before the rounding bias so the add cannot wrap.
        assign w_rnd = ($signed({{(EW-AW){w_acc_next[i][AW-1]}}, w_acc_next[i]}) + RND_BIAS) >>> SHIFT;
        assign w_hi  = (w_rnd > SAT_MAX);
        assign w_lo  = (w_rnd < SAT_MIN);

        assign w_m_data_next[i*RW +: RW] = w_hi ? OUT_MAX : (w_lo ? OUT_MIN : w_rnd[RW-1:0]);
        assign w_ovf_next[i]             = w_hi | w_lo;
    end

    always_ff @(posedge clk) begin
        // NOTE: the accumulator array is reset explicitly because a reset must discard any partial frame.
        if (rst) begin
            r_tap <= '0;
            for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_m_ovf    <= '0;
            r_err_sync <= 1'b0;
        end else if (ena) begin
            // NOTE: non-blocking updates so every register sees pre-edge values of its neighbours.
            if (w_accept) begin
                for (int i = 0; i < NCH; i++) r_acc[i] <= w_acc_next[i];
                r_tap <= w_resync ? TW'(1) : (w_last ? '0 : r_tap + 1'b1);
                if (w_resync) r_err_sync <= 1'b1;
            end
            if (w_load) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_m_data_next;
                r_m_ovf   <= w_ovf_next;
            end else if (r_m_valid & m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign m_ovf    = r_m_ovf;
    assign err_sync = r_err_sync;

endmodule

// File: tb/tb_dct_mac_array.sv
// Directed testbench for dct_mac_array with two channels and four taps per frame.
module tb_dct_mac_array;

    logic              clk = 1'b0;
    logic              rst;
    logic              ena;
    logic              s_valid;
    logic              s_ready;
    logic signed [7:0] s_data;
    logic              s_first;
    logic [23:0]       s_coef;
    logic              m_valid;
    logic              m_ready;
    logic [23:0]       m_data;
    logic [1:0]        m_ovf;
    logic              err_sync;

    int errors = 0;
    int checks = 0;

    wire signed [11:0] ch0 = m_data[11:0];
    wire signed [11:0] ch1 = m_data[23:12];

    dct_mac_array #(
        .DW(8), .CW(12), .NCH(2), .NTAP(4), .SHIFT(4), .RW(12)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_first(s_first), .s_coef(s_coef),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_ovf(m_ovf), .err_sync(err_sync)
    );

    always #5 clk = ~clk;

    // Drives one sample; returns #1 after the edge that accepted it.
    task automatic send(input logic signed [7:0] d, input logic signed [11:0] c0,
                        input logic signed [11:0] c1, input logic first);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_coef  = {c1, c0};
        s_first = first;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_ready stayed %0b, required 1", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_first = 1'b0;
    endtask

    task automatic pop();
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic frame_1234();
        send(8'sd1, 12'sd16, -12'sd16, 1'b1);
        send(8'sd2, 12'sd16, -12'sd16, 1'b0);
        send(8'sd3, 12'sd16, -12'sd16, 1'b0);
        send(8'sd4, 12'sd16, -12'sd16, 1'b0);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (m_valid !== 1'b0 || m_data !== 24'h0 || m_ovf !== 2'b00 || err_sync !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%0b data=%h ovf=%b err=%0b, required 0/000000/00/0",
                     m_valid, m_data, m_ovf, err_sync);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_s_ready: got %0b, required 1", s_ready);
        end
    endtask

    task automatic test_basic();
        send(8'sd1, 12'sd16, -12'sd16, 1'b1);
        send(8'sd2, 12'sd16, -12'sd16, 1'b0);
        send(8'sd3, 12'sd16, -12'sd16, 1'b0);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid: got %0b, required 0", m_valid);
        end
        send(8'sd4, 12'sd16, -12'sd16, 1'b0);
        checks++;
        if (m_valid !== 1'b1 || ch0 !== 12'sd10 || ch1 !== -12'sd10 || m_ovf !== 2'b00) begin
            errors++;
            $display("FAIL basic_result: valid=%0b ch0=%0d ch1=%0d ovf=%b, required 1/10/-10/00",
                     m_valid, ch0, ch1, m_ovf);
        end
        pop();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_pop: valid=%0b, required 0", m_valid);
        end
    endtask

    task automatic test_rounding();
        send(8'sd1, 12'sd8, -12'sd8, 1'b1);
        send(8'sd0, 12'sd0, 12'sd0, 1'b0);
        send(8'sd0, 12'sd0, 12'sd0, 1'b0);
        send(8'sd0, 12'sd0, 12'sd0, 1'b0);
        checks++;
        if (ch0 !== 12'sd1 || ch1 !== 12'sd0 || m_ovf !== 2'b00) begin
            errors++;
            $display("FAIL round_half: ch0=%0d ch1=%0d ovf=%b, required 1/0/00", ch0, ch1, m_ovf);
        end
        pop();
        send(8'sd1, -12'sd9, 12'sd9, 1'b1);
        send(8'sd0, 12'sd0, 12'sd0, 1'b0);
        send(8'sd0, 12'sd0, 12'sd0, 1'b0);
        send(8'sd0, 12'sd0, 12'sd0, 1'b0);
        checks++;
        if (ch0 !== -12'sd1 || ch1 !== 12'sd1) begin
            errors++;
            $display("FAIL round_nine: ch0=%0d ch1=%0d, required -1/1", ch0, ch1);
        end
        pop();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) send(8'sd127, 12'sd2047, -12'sd2048, (i == 0));
        checks++;
        if (ch0 !== 12'sd2047 || ch1 !== -12'sd2048 || m_ovf !== 2'b11) begin
            errors++;
            $display("FAIL sat_clamp: ch0=%0d ch1=%0d ovf=%b, required 2047/-2048/11", ch0, ch1, m_ovf);
        end
        pop();
        // 16*2047 rounds to exactly 2047 and 16*-2048 to exactly -2048: in range, no clamp.
        send(8'sd16, 12'sd2047, -12'sd2048, 1'b1);
        send(8'sd0, 12'sd0, 12'sd0, 1'b0);
        send(8'sd0, 12'sd0, 12'sd0, 1'b0);
        send(8'sd0, 12'sd0, 12'sd0, 1'b0);
        checks++;
        if (ch0 !== 12'sd2047 || ch1 !== -12'sd2048 || m_ovf !== 2'b00) begin
            errors++;
            $display("FAIL sat_edge: ch0=%0d ch1=%0d ovf=%b, required 2047/-2048/00", ch0, ch1, m_ovf);
        end
        pop();
    endtask

    task automatic test_back_to_back();
        frame_1234();
        send(8'sd5, 12'sd16, -12'sd16, 1'b1);
        send(8'sd6, 12'sd16, -12'sd16, 1'b0);
        send(8'sd7, 12'sd16, -12'sd16, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'sd8;
        s_coef  = {-12'sd16, 12'sd16};
        repeat (2) @(negedge clk);
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: s_ready=%0b, required 0", s_ready);
        end
        checks++;
        if (m_valid !== 1'b1 || ch0 !== 12'sd10 || ch1 !== -12'sd10) begin
            errors++;
            $display("FAIL bp_hold: valid=%0b ch0=%0d ch1=%0d, required 1/10/-10", m_valid, ch0, ch1);
        end
        m_ready = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: s_ready=%0b, required 1", s_ready);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || ch0 !== 12'sd26 || ch1 !== -12'sd26) begin
            errors++;
            $display("FAIL bp_new: valid=%0b ch0=%0d ch1=%0d, required 1/26/-26", m_valid, ch0, ch1);
        end
        pop();
    endtask

    task automatic test_resync_enable();
        checks++;
        if (err_sync !== 1'b0) begin
            errors++;
            $display("FAIL resync_pre: err_sync=%0b, required 0", err_sync);
        end
        send(8'sd1, 12'sd16, -12'sd16, 1'b1);
        send(8'sd2, 12'sd16, -12'sd16, 1'b0);
        send(8'sd5, 12'sd16, -12'sd16, 1'b1);
        checks++;
        if (err_sync !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL resync_flag: err=%0b valid=%0b, required 1/0", err_sync, m_valid);
        end
        send(8'sd6, 12'sd16, -12'sd16, 1'b0);
        send(8'sd7, 12'sd16, -12'sd16, 1'b0);
        send(8'sd8, 12'sd16, -12'sd16, 1'b0);
        checks++;
        if (m_valid !== 1'b1 || ch0 !== 12'sd26 || ch1 !== -12'sd26) begin
            errors++;
            $display("FAIL resync_frame: valid=%0b ch0=%0d ch1=%0d, required 1/26/-26", m_valid, ch0, ch1);
        end
        pop();

        send(8'sd1, 12'sd16, -12'sd16, 1'b1);
        send(8'sd2, 12'sd16, -12'sd16, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'sd3;
        s_coef  = {-12'sd16, 12'sd16};
        ena     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b0) begin
                errors++;
                $display("FAIL ena_ready: cycle %0d s_ready=%0b, required 0", i, s_ready);
            end
        end
        ena = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        send(8'sd4, 12'sd16, -12'sd16, 1'b0);
        checks++;
        if (m_valid !== 1'b1 || ch0 !== 12'sd10 || ch1 !== -12'sd10) begin
            errors++;
            $display("FAIL ena_result: valid=%0b ch0=%0d ch1=%0d, required 1/10/-10", m_valid, ch0, ch1);
        end
        ena     = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL ena_hold_pop: valid=%0b, required 1", m_valid);
        end
        ena = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL ena_pop: valid=%0b, required 0", m_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        frame_1234();
        send(8'sd9, 12'sd16, -12'sd16, 1'b1);
        send(8'sd9, 12'sd16, -12'sd16, 1'b0);
        apply_reset();
        checks++;
        if (m_valid !== 1'b0 || m_data !== 24'h0 || m_ovf !== 2'b00 || err_sync !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: valid=%0b data=%h ovf=%b err=%0b, required 0/000000/00/0",
                     m_valid, m_data, m_ovf, err_sync);
        end
        frame_1234();
        checks++;
        if (m_valid !== 1'b1 || ch0 !== 12'sd10 || ch1 !== -12'sd10 || m_ovf !== 2'b00 || err_sync !== 1'b0) begin
            errors++;
            $display("FAIL midreset_frame: valid=%0b ch0=%0d ch1=%0d ovf=%b err=%0b, required 1/10/-10/00/0",
                     m_valid, ch0, ch1, m_ovf, err_sync);
        end
        pop();
    endtask

    initial begin
        rst     = 1'b1;
        ena     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_first = 1'b0;
        s_coef  = '0;
        m_ready = 1'b0;
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_resync_enable();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
